// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding for serial_adder
package serial_adder_pkg;
    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;
    typedef enum logic [ST_W-1:0] {IDLE = ST_IDLE, RUN = ST_RUN, DONE = ST_DONE} state_t;
endpackage

// File: rtl/fulladder.sv
// fulladder: one-bit full adder slice
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder, optional signed overflow port via SERIAL_ADDER_OVF_EN
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nx;
    logic             carry, fa_sum, fa_carry;
    logic [CW-1:0]    cnt;
    fulladder u_fa (.a(a_sr[0]), .b(b_sr[0]), .c(carry), .sum(fa_sum), .carry(fa_carry));
    // shift form avoids an illegal part-select when WIDTH == 1
    assign sum_nx    = (sum_sr >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sr   <= a;
                    b_sr   <= b;
                    carry  <= cin;
                    cnt    <= '0;
                    sum_sr <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    sum_sr <= sum_nx;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_carry;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        sum   <= sum_nx;
                        cout  <= fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= carry ^ fa_carry;
`endif
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (WIDTH 8 and 1), ovf checks under SERIAL_ADDER_OVF_EN
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       in_ready, out_valid, cout;
    logic [7:0] sum;
    logic       v1 = 1'b0, r1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic       rdy1, ov1, s1, co1;
    logic       ovf, ovf1;
    int         total = 0, bad = 0;
    logic [9:0] sb[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .a(a1), .b(b1), .cin(c1),
        .out_valid(ov1), .out_ready(r1), .sum(s1), .cout(co1)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf  = 1'b0;
    assign ovf1 = 1'b0;
`endif

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {ovf, cout, sum}: ovf is carry into bit 7 xor carry out of bit 7
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic ci);
        logic [8:0] s;
        logic [7:0] lo;
        s  = {1'b0, x} + {1'b0, y} + {8'd0, ci};
        lo = {1'b0, x[6:0]} + {1'b0, y[6:0]} + {7'd0, ci};
        return {lo[7] ^ s[8], s};
    endfunction

    task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic ci,
                         input int hold, input bit keep_valid, input bit early_ready);
        int n;
        logic [9:0] e;
        chk("idle_ready", 16'(in_ready), 16'd1);
        a = x; b = y; cin = ci; in_valid = 1'b1; out_ready = early_ready;
        sb.push_back(model(x, y, ci));
        @(posedge clk); #1;
        if (keep_valid) begin a = 8'h11; b = 8'h00; end
        else in_valid = 1'b0;
        chk("busy_ready", 16'(in_ready), 16'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (!out_valid) chk("run_ready", 16'(in_ready), 16'd0);
        end
        chk("latency", 16'(n), 16'd8);
        e = sb.pop_front();
        chk("sum", 16'(sum), 16'(e[7:0]));
        chk("cout", 16'(cout), 16'(e[8]));
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", 16'(ovf), 16'(e[9]));
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 16'({in_ready, out_valid}), 16'b01);
            chk("hold_result", 16'({cout, sum}), 16'(e[8:0]));
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("back_idle", 16'({in_ready, out_valid}), 16'b10);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 16'(in_ready), 16'd1);
        chk("rst_valid", 16'(out_valid), 16'd0);
        chk("rst_sum", 16'({cout, sum}), 16'd0);
        chk("rst1_state", 16'({rdy1, ov1, co1, s1}), 16'b1000);
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b0);
        do_op(8'h3C, 8'h5A, 1'b1, 0, 1'b0, 1'b0);
        do_op(8'h80, 8'h80, 1'b0, 5, 1'b0, 1'b0);
        do_op(8'h01, 8'h02, 1'b0, 2, 1'b1, 1'b0);
        do_op(8'hA5, 8'h3C, 1'b1, 0, 1'b0, 1'b1);
        do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0, 1'b0);
        do_op(8'h80, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
        a = 8'h55; b = 8'h0F; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun_ready", 16'(in_ready), 16'd1);
        chk("midrun_valid", 16'(out_valid), 16'd0);
        chk("midrun_result", 16'({cout, sum}), 16'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("midrun_ovf", 16'(ovf), 16'd0);
`endif
        do_op(8'h10, 8'h20, 1'b0, 0, 1'b0, 1'b0);
        chk("sb_empty", 16'(sb.size()), 16'd0);
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; v1 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0;
        chk("w1_run", 16'({rdy1, ov1}), 16'b00);
        @(posedge clk); #1;
        chk("w1_done", 16'({rdy1, ov1}), 16'b01);
        chk("w1_result", 16'({co1, s1}), 16'b10);
`ifdef SERIAL_ADDER_OVF_EN
        chk("w1_ovf", 16'(ovf1), 16'd1);
`endif
        r1 = 1'b1;
        @(posedge clk); #1;
        chk("w1_idle", 16'({rdy1, ov1}), 16'b10);
        r1 = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
